pcie_app_rst_ctrl: RTL and testbench

Application-side reset and link-qualification controller, directly downstream of the HIP reset block. Consumes its `app_rstn` plus the raw LTSSM state and releases user logic only after the link has held L0 stably. Quiesces user transmit on link loss, with a bounded drain. Raises a retrain request if L0 is not reached within a timeout.

---
 rtl/pcie_app_rst_ctrl.sv | 129 ++++++++++++
 tb/tb_pcie_app_rst_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pcie_app_rst_ctrl.sv
// Application reset and link-qualification controller: releases user logic after stable L0,
// drains on link loss, pulses retrain on L0 timeout. Optional macro: PCIE_APP_RST_SIM_SHORTEN_EN.
module pcie_app_rst_ctrl #(
   parameter int unsigned STABLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned TMO_W          = 20,
   parameter int unsigned DRAIN_CYCLES   = 256,
   parameter logic [4:0]  L0_CODE        = 5'h0F
) (
   input  logic       pld_clk,
   input  logic       app_rstn,
   input  logic [4:0] ltssm,
   input  logic       quiesce_ack,
   input  logic       test_sim,
   output logic       user_rstn,
   output logic       tx_en,
   output logic       quiesce_req,
   output logic       retrain_req,
   output logic [1:0] link_state,
   output logic [7:0] timeout_count
);

   localparam int unsigned SW = $clog2(STABLE_CYCLES + 4);
   localparam int unsigned DW = $clog2(DRAIN_CYCLES + 16);

   typedef enum logic [1:0] {
      WAIT_L0 = 2'd0,
      LINK_UP = 2'd1,
      DRAIN   = 2'd2,
      TIMEOUT = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [4:0]       ltssm_r;
   logic [SW-1:0]    stable_cnt, stable_nx;
   logic [TMO_W-1:0] tmo_cnt, tmo_nx;
   logic [DW-1:0]    drain_cnt, drain_nx;
   logic [7:0]       tcount_nx;
   logic [31:0]      stable_last, tmo_last, drain_last;
   logic             is_l0;

`ifdef PCIE_APP_RST_SIM_SHORTEN_EN
   assign stable_last = test_sim ? 32'd3   : STABLE_CYCLES - 1;
   assign tmo_last    = test_sim ? 32'd255 : TIMEOUT_CYCLES - 1;
   assign drain_last  = test_sim ? 32'd15  : DRAIN_CYCLES - 1;
`else
   logic unused_test_sim;
   assign unused_test_sim = test_sim;
   assign stable_last     = STABLE_CYCLES - 1;
   assign tmo_last        = TIMEOUT_CYCLES - 1;
   assign drain_last      = DRAIN_CYCLES - 1;
`endif

   assign is_l0      = (ltssm_r == L0_CODE);
   assign link_state = state;

   always_ff @(posedge pld_clk or negedge app_rstn) begin
      if (!app_rstn) ltssm_r <= '0;
      else           ltssm_r <= ltssm;
   end

   always_comb begin
      state_nx  = state;
      stable_nx = stable_cnt;
      tmo_nx    = tmo_cnt;
      drain_nx  = drain_cnt;
      case (state)
         WAIT_L0: begin
            stable_nx = is_l0 ? stable_cnt + SW'(1) : '0;
            tmo_nx    = tmo_cnt + TMO_W'(1);
            // Qualification is tested first so it wins over a coincident timeout.
            if (is_l0 && (32'(stable_cnt) == stable_last)) state_nx = LINK_UP;
            else if (32'(tmo_cnt) == tmo_last)             state_nx = TIMEOUT;
         end
         TIMEOUT: begin
            state_nx  = WAIT_L0;
            stable_nx = '0;
            tmo_nx    = '0;
            drain_nx  = '0;
         end
         LINK_UP: begin
            if (!is_l0) begin
               state_nx = DRAIN;
               drain_nx = '0;
            end
         end
         DRAIN: begin
            drain_nx = drain_cnt + DW'(1);
            if (quiesce_ack || (32'(drain_cnt) == drain_last)) begin
               state_nx  = WAIT_L0;
               stable_nx = '0;
               tmo_nx    = '0;
               drain_nx  = '0;
            end else if (is_l0) begin
               state_nx = LINK_UP;
            end
         end
         default: state_nx = WAIT_L0;
      endcase
      tcount_nx = timeout_count;
      if ((state_nx == TIMEOUT) && (timeout_count != 8'hFF)) tcount_nx = timeout_count + 8'd1;
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge pld_clk or negedge app_rstn) begin
      if (!app_rstn) begin
         state         <= WAIT_L0;
         stable_cnt    <= '0;
         tmo_cnt       <= '0;
         drain_cnt     <= '0;
         user_rstn     <= 1'b0;
         tx_en         <= 1'b0;
         quiesce_req   <= 1'b0;
         retrain_req   <= 1'b0;
         timeout_count <= '0;
      end else begin
         state         <= state_nx;
         stable_cnt    <= stable_nx;
         tmo_cnt       <= tmo_nx;
         drain_cnt     <= drain_nx;
         user_rstn     <= (state_nx == LINK_UP) || (state_nx == DRAIN);
         tx_en         <= (state_nx == LINK_UP);
         quiesce_req   <= (state_nx == DRAIN);
         retrain_req   <= (state_nx == TIMEOUT);
         timeout_count <= tcount_nx;
      end
   end

endmodule

// File: tb/tb_pcie_app_rst_ctrl.sv
// Scoreboard bench for pcie_app_rst_ctrl: expected outputs are queued per cycle and checked at negedge.
module tb_pcie_app_rst_ctrl;

   localparam int unsigned TMO = 100;
`ifdef PCIE_APP_RST_SIM_SHORTEN_EN
   localparam int unsigned S_EFF = 4;
`else
   localparam int unsigned S_EFF = 16;
`endif

   localparam logic [13:0] M_U   = 14'h2000;
   localparam logic [13:0] M_T   = 14'h1000;
   localparam logic [13:0] M_Q   = 14'h0800;
   localparam logic [13:0] M_R   = 14'h0400;
   localparam logic [13:0] M_L   = 14'h0300;
   localparam logic [13:0] M_C   = 14'h00FF;
   localparam logic [13:0] M_FSM = M_U | M_T | M_Q | M_R | M_L;

   logic       pld_clk = 1'b0;
   logic       app_rstn;
   logic [4:0] ltssm;
   logic       quiesce_ack;
   logic       test_sim;
   logic       user_rstn, tx_en, quiesce_req, retrain_req;
   logic [1:0] link_state;
   logic [7:0] timeout_count;
   logic [13:0] obs;

   pcie_app_rst_ctrl #(
      .STABLE_CYCLES (16),
      .TIMEOUT_CYCLES(TMO),
      .TMO_W         (20),
      .DRAIN_CYCLES  (256),
      .L0_CODE       (5'h0F)
   ) dut (
      .pld_clk      (pld_clk),
      .app_rstn     (app_rstn),
      .ltssm        (ltssm),
      .quiesce_ack  (quiesce_ack),
      .test_sim     (test_sim),
      .user_rstn    (user_rstn),
      .tx_en        (tx_en),
      .quiesce_req  (quiesce_req),
      .retrain_req  (retrain_req),
      .link_state   (link_state),
      .timeout_count(timeout_count)
   );

   always #5 pld_clk = ~pld_clk;

   assign obs = {user_rstn, tx_en, quiesce_req, retrain_req, link_state, timeout_count};

   int unsigned cyc = 0;
   always @(posedge pld_clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      string       tag;
      logic [13:0] exp;
      logic [13:0] mask;
   } exp_t;

   exp_t sb[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check_val(input string tag, input logic [13:0] act, input logic [13:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic expect_at(input int unsigned c, input string tag,
                            input logic [13:0] e, input logic [13:0] m);
      exp_t x;
      x.cyc = c; x.tag = tag; x.exp = e; x.mask = m;
      sb.push_back(x);
   endtask

   function automatic logic [13:0] mk(input logic u, input logic t, input logic q, input logic r,
                                      input logic [1:0] ls, input logic [7:0] tc);
      return {u, t, q, r, ls, tc};
   endfunction

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge pld_clk);
      #1;
   endtask

   always @(negedge pld_clk) begin
      for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check_val($sformatf("%s@%0d", sb[i].tag, cyc), obs & sb[i].mask, sb[i].exp & sb[i].mask);
            sb.delete(i);
         end
      end
   end

   initial begin
      int unsigned b, b2;
      logic [7:0]  tc, tcp;
      app_rstn    = 1'b0;
      ltssm       = 5'h00;
      quiesce_ack = 1'b0;
      test_sim    = 1'b0;
      tick(3);
      check_val("reset_state", obs, 14'h0000);

      // release after 16 stable L0 cycles
      app_rstn = 1'b1;
      b = cyc;
      ltssm = 5'h0F;
      expect_at(b + 16, "hold_before_release", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0), M_FSM);
      expect_at(b + 17, "release", mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0), M_FSM | M_C);
      tick(20);

      // link loss then quiesce ack
      b = cyc;
      ltssm = 5'h0C;
      expect_at(b + 1, "loss_still_up", mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0), M_FSM);
      expect_at(b + 2, "drain_entry", mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'd0), M_FSM);
      expect_at(b + 5, "drain_before_ack", mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'd0), M_FSM);
      expect_at(b + 6, "ack_exit", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0), M_FSM);
      tick(5);
      quiesce_ack = 1'b1;
      tick(1);
      quiesce_ack = 1'b0;
      tick(2);

      // one-cycle glitch at qualification cycle 10 restarts the count
      b = cyc;
      expect_at(b + 17, "glitch_no_early", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0), M_FSM);
      expect_at(b + 27, "glitch_hold", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0), M_FSM);
      expect_at(b + 28, "glitch_release", mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0), M_FSM);
      ltssm = 5'h0F;
      tick(10);
      ltssm = 5'h0E;
      tick(1);
      ltssm = 5'h0F;
      tick(20);

      // short 3-cycle loss returns to LINK_UP without dropping user_rstn
      b = cyc;
      for (int i = 1; i <= 8; i++) expect_at(b + i, "short_loss_rstn", M_U, M_U);
      for (int i = 2; i <= 4; i++)
         expect_at(b + i, "short_loss_drain", mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'd0), M_FSM);
      expect_at(b + 5, "short_loss_return", mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0), M_FSM);
      ltssm = 5'h0C;
      tick(3);
      ltssm = 5'h0F;
      tick(10);

      // drain expiry with no ack
      b = cyc;
      ltssm = 5'h0C;
      expect_at(b + 2, "expiry_entry", mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'd0), M_FSM);
      expect_at(b + 257, "expiry_last", mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'd0), M_FSM);
      expect_at(b + 258, "expiry_exit", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0), M_FSM);
      tick(260);

      // async reset in DRAIN
      b = cyc;
      ltssm = 5'h0F;
      expect_at(b + 17, "requalify", mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0), M_FSM);
      tick(20);
      b2 = cyc;
      ltssm = 5'h0C;
      expect_at(b2 + 4, "pre_reset_drain", mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'd0), M_FSM);
      tick(5);
      app_rstn = 1'b0;
      #1;
      check_val("async_reset", obs, 14'h0000);
      tick(2);

      // test_sim select: shortened only when the macro is built in
      test_sim = 1'b1;
      ltssm = 5'h0F;
      app_rstn = 1'b1;
      b = cyc;
      expect_at(b + S_EFF, "sim_hold", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0), M_FSM);
      expect_at(b + S_EFF + 1, "sim_release", mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0), M_FSM);
      tick(S_EFF + 4);
      test_sim = 1'b0;
      app_rstn = 1'b0;
      ltssm = 5'h02;
      tick(2);

      // periodic retrain and timeout_count saturation
      app_rstn = 1'b1;
      b = cyc;
      for (int i = 1; i <= 260; i++) begin
         int unsigned p;
         p   = b + TMO + (i - 1) * (TMO + 1);
         tc  = 8'((i < 255) ? i : 255);
         tcp = 8'((i - 1 < 255) ? i - 1 : 255);
         expect_at(p - 1, "tmo_before", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, tcp), M_R | M_L | M_C);
         expect_at(p,     "tmo_pulse",  mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, tc),  M_FSM | M_C);
         expect_at(p + 1, "tmo_after",  mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, tc),  M_R | M_L | M_C);
      end
      tick(TMO + 259 * (TMO + 1) + 3);

      check_val("scoreboard_drained", 14'(sb.size()), 14'h0000);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
